// File: rtl/des_pkg.sv
// Shared DES constants, FSM encoding and permutation/round helpers
// used by the iterative engine and its subkey generator.
package des_pkg;

    localparam int BLK_W  = 64;
    localparam int KEY_W  = 56;
    localparam int SUB_W  = 48;
    localparam int HALF_W = 28;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROUND,
        S_DONE
    } state_t;

    localparam int SHIFT_TBL [16] = '{
        1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
    };

    localparam int PC1_T [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_T [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    localparam int IP_T [64] = '{
        58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
        62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
        57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
        61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7
    };

    localparam int FP_T [64] = '{
        40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
        38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
        36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
        34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25
    };

    localparam int E_T [48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    localparam int P_T [32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // Entry 0 of each S-box sits in the top nibble; row-major 4x16.
    localparam logic [255:0] SBOX [8] = '{
        256'hE4D12FB83A6C59070F74E2D1A6CB953841E8D62BFC973A50FC8249175B3EA06D,
        256'hF18E6B34972DC05A3D47F28EC01A69B50E7BA4D158C6932FD8A13F42B67C05E9,
        256'hA09E63F51DC7B428D709346A285ECBF1D6498F30B12C5AE71AD069874FE3B52C,
        256'h7DE3069A1285BC4FD8B56F03472C1AE9A690CB7DF13E52843F06A1D8945BC72E,
        256'h2C417AB6853FD0E9EB2C47D150FA3986421BAD78F9C5630EB8C71E2D6F09A453,
        256'hC1AF92680D34E75BAF427C9561DE0B389EF528C3704A1DB6432C95FABE17608D,
        256'h4B2EF08D3C975A61D0B7491AE35C2F8614BDC37EAF6805926BD814A7950FE23C,
        256'hD2846FB1A93E50C71FD8A374C56B0E927B419CE206ADF35821E74A8DFC90356B
    };

    function automatic logic [63:0] des_ip(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
        return y;
    endfunction

    function automatic logic [63:0] des_ip_inv(input logic [63:0] x);
        logic [63:0] y;
        for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
        return y;
    endfunction

    function automatic logic [55:0] des_pc1(input logic [63:0] x);
        logic [55:0] y;
        for (int i = 0; i < 56; i++) y[55-i] = x[64-PC1_T[i]];
        return y;
    endfunction

    function automatic logic [47:0] des_pc2(input logic [55:0] x);
        logic [47:0] y;
        for (int i = 0; i < 48; i++) y[47-i] = x[56-PC2_T[i]];
        return y;
    endfunction

    function automatic logic [31:0] des_f(
        input logic [31:0] r,
        input logic [47:0] k
    );
        logic [47:0] x;
        logic [31:0] s;
        logic [31:0] y;
        logic [5:0]  b;
        int          idx;
        for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
        x = x ^ k;
        for (int j = 0; j < 8; j++) begin
            b   = x[47-6*j -: 6];
            idx = int'({b[5], b[0], b[4:1]});
            s[31-4*j -: 4] = SBOX[j][255-4*idx -: 4];
        end
        for (int i = 0; i < 32; i++) y[31-i] = s[32-P_T[i]];
        return y;
    endfunction

    function automatic logic [27:0] rotl(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[26:0], x[27]};
            2:       return {x[25:0], x[27:26]};
            default: return x;
        endcase
    endfunction

    function automatic logic [27:0] rotr(input logic [27:0] x, input int n);
        case (n)
            1:       return {x[0], x[27:1]};
            2:       return {x[1:0], x[27:2]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/des_subkey_gen.sv
// Combinational on-the-fly key schedule: rotates {C,D} for the current
// round (left for encrypt, right for decrypt) and emits PC2 of the result.
module des_subkey_gen
    import des_pkg::*;
#(
    parameter bit DECRYPT_EN = 1'b1
) (
    input  logic [KEY_W-1:0] i_cd,
    input  logic [4:0]       i_round,
    input  logic             i_mode,
    output logic [KEY_W-1:0] o_cd,
    output logic [SUB_W-1:0] o_kn
);

    logic [3:0]       w_fidx;
    logic [KEY_W-1:0] w_fwd;

    assign w_fidx = i_round[3:0] - 4'd1;
    assign w_fwd  = {rotl(i_cd[KEY_W-1:HALF_W], SHIFT_TBL[w_fidx]),
                     rotl(i_cd[HALF_W-1:0], SHIFT_TBL[w_fidx])};

    generate
        if (DECRYPT_EN) begin : g_rev
            logic [3:0]       w_ridx;
            int               w_ramt;
            logic [KEY_W-1:0] w_rev;
            // Round n of decrypt undoes the shift that led into key 18-n;
            // round 1 starts from PC1 since the total rotation is 28.
            assign w_ridx = 4'd1 - i_round[3:0];
            assign w_ramt = (i_round == 5'd1) ? 0 : SHIFT_TBL[w_ridx];
            assign w_rev  = {rotr(i_cd[KEY_W-1:HALF_W], w_ramt),
                             rotr(i_cd[HALF_W-1:0], w_ramt)};
            assign o_cd   = i_mode ? w_rev : w_fwd;
        end else begin : g_fwd
            assign o_cd = w_fwd;
        end
    endgenerate

    assign o_kn = des_pc2(o_cd);

endmodule

// File: rtl/des_iter_engine.sv
// Iterative DES engine: one Feistel round per clock with valid/ready
// handshakes on both sides and an on-the-fly key schedule.
module des_iter_engine
    import des_pkg::*;
#(
    parameter bit DECRYPT_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           decrypt,
    input  logic [BLK_W:1] din,
    input  logic [BLK_W:1] key,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [BLK_W:1] dout,
    output logic           busy
);

    state_t           r_state;
    state_t           w_state_nx;
    logic [31:0]      r_l;
    logic [31:0]      r_r;
    logic [KEY_W-1:0] r_cd;
    logic [4:0]       r_round;
    logic             r_mode;
    logic [BLK_W:1]   r_dout;
    logic [KEY_W-1:0] w_cd_nx;
    logic [SUB_W-1:0] w_kn;
    logic [31:0]      w_f;
    logic             w_accept;

    des_subkey_gen #(
        .DECRYPT_EN(DECRYPT_EN)
    ) u_keygen (
        .i_cd   (r_cd),
        .i_round(r_round),
        .i_mode (r_mode),
        .o_cd   (w_cd_nx),
        .o_kn   (w_kn)
    );

    assign w_f      = des_f(r_r, w_kn);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next-state: accept in IDLE, 16 rounds, hold result until taken
    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE:  if (in_valid) w_state_nx = S_ROUND;
            S_ROUND: if (r_round == 5'd16) w_state_nx = S_DONE;
            S_DONE:  if (out_ready) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Datapath: load on accept, one round per cycle, latch final block
    always_ff @(posedge clk) begin
        if (rst) begin
            r_l     <= '0;
            r_r     <= '0;
            r_cd    <= '0;
            r_round <= '0;
            r_mode  <= 1'b0;
            r_dout  <= '0;
        end else if (w_accept) begin
            {r_l, r_r} <= des_ip(din);
            r_cd       <= des_pc1(key);
            r_mode     <= decrypt & DECRYPT_EN;
            r_round    <= 5'd1;
        end else if (r_state == S_ROUND) begin
            r_l  <= r_r;
            r_r  <= r_l ^ w_f;
            r_cd <= w_cd_nx;
            if (r_round != 5'd16) r_round <= r_round + 5'd1;
            else r_dout <= des_ip_inv({r_l ^ w_f, r_r});
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign dout      = r_dout;

endmodule

// File: doc/des_iter_engine.md
Name: des_iter_engine

Overview:
Iterative, area-reduced DES engine that computes one Feistel round per clock instead of the fully unrolled 16-round datapath. It contains the round-sequencing FSM, an on-the-fly subkey generator that runs forward for encryption and backward for decryption, and valid/ready handshakes on input and output. It reuses the existing IP, IP_inv and f blocks and sits between the steganography-embed front end and the block-data source.

Parameters:
DECRYPT_EN, 1, when 0 the decrypt input is ignored (treated as 0) and the reverse key-rotation logic is removed.

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request carries valid din/key/decrypt
in_ready  output  1  engine can accept a request (high only in IDLE)
decrypt  input  1  0 = encrypt, 1 = decrypt; sampled on accept
din  input  [64:1]  plaintext or ciphertext block, bit 1 = MSB
key  input  [64:1]  DES key including parity bits (parity ignored)
out_valid  output  1  dout holds a finished result
out_ready  input  1  consumer accepts dout
dout  output  [64:1]  result block
busy  output  1  high in ROUND or DONE

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, dout=0, round counter=0, and L/R/C/D registers=0. Reset asserted in any state aborts the operation within one cycle; the partial result is discarded and never presented.
- States:
  - IDLE: in_ready=1. When in_valid=1 (the accept cycle): register {L,R}=IP(din), {C,D}=PC1(key), mode=decrypt&DECRYPT_EN, and round=1. Go to ROUND.
  - ROUND: one round per cycle for round=1..16.
    - Subkey for round n is PC2 of the rotated C,D for that round.
    - Encrypt: before round n, rotate left by 1 for n in {1,2,9,16}, otherwise by 2.
    - Decrypt: round 1 uses the unrotated PC1 value, because the total rotation is 28 and therefore equals the identity. Before round n≥2, rotate right by 1 for n in {2,9,16}, otherwise by 2.
    - Round update: L<=R, R<=L^f(R,Kn).
    - After round 16: dout<=IP_inv({R,L}) (swapped), out_valid<=1, go to DONE.
  - DONE: out_valid=1 and dout is held stable until out_ready=1. On the handshake cycle: out_valid<=0 and go to IDLE; in_ready rises the next cycle. There is no overlap of output accept and new input accept.
- Latency: the request is accepted on cycle 0 and out_valid rises after the edge ending cycle 16 (17 cycles accept-to-valid). Throughput is one block per 18 cycles minimum.
- in_valid while not in IDLE is ignored: no queuing, and din/key need not be held after accept.
- out_ready while out_valid=0 has no effect.
- dout keeps its last value in IDLE and ROUND; only out_valid qualifies it.
- Round counter is 5 bits. The ROUND→DONE transition occurs on round==16, and the counter never wraps past 16.
- Parity bits key[8,16,...,64] have no effect on the result.

Decomposition:
- Shared package des_pkg holds:
  - PC1 and PC2 permutation tables as constant index arrays;
  - the 16-entry shift-amount table;
  - the FSM state encoding (IDLE, ROUND, DONE);
  - block and key width constants (64, 56, 48, 28).
- One sub-module, des_subkey_gen. It is combinational: inputs are {C,D}, round and mode; outputs are the next {C,D} and the 48-bit Kn.
- The existing f, IP and IP_inv blocks are instantiated unchanged.

Test Plan:
1. Encrypt: key=133457799BBCDFF1, din=0123456789ABCDEF → dout=85E813540F0AB405, with out_valid exactly 17 cycles after accept.
2. Decrypt: same key, din=85E813540F0AB405, decrypt=1 → dout=0123456789ABCDEF. Also key=0E329232EA6D0D73 with din=0000000000000000 decrypt → 8787878787878787.
3. Backpressure: hold out_ready=0 for 10 cycles after out_valid. dout and out_valid must stay stable, in_ready=0, and a second in_valid pulse must be ignored. Release → IDLE, then the second request is accepted normally.
4. Reset mid-operation: assert rst during round 8 → next cycle in_ready=1, out_valid=0, busy=0, and no stray output. A new encrypt of vector 1 must give the correct result.
5. Parity independence and back-to-back:
   - key=133457799BBCDFF1 with all parity bits flipped must give the same ciphertext.
   - Hold in_valid continuously with out_ready=1: consecutive accepts are 18 cycles apart.
6. DECRYPT_EN=0 build: decrypt=1 with vector 1 inputs → dout=85E813540F0AB405 (the encrypt result).
